// File: rtl/seq_pattern_detector.sv
// Serial pattern detector with a runtime-loadable pattern, a length and an overlap mode.
// The history shift register and the fill count track recent valid bits. A registered
// one-cycle pulse marks each match.
// Build option: define SEQDET_MATCH_COUNT_EN to add the saturating match counter and its
// synchronous clear. Without it, match_count reads 0 and count_clear has no effect.
module seq_pattern_detector #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sequence_in,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             count_clear,
  output logic             detector_out,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [LEN_W-1:0] PAT_W_L     = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] MIN_LEN     = LEN_W'(2);
  localparam logic [LEN_W-1:0] RST_LEN     = LEN_W'(3);
  localparam logic [PAT_W-1:0] RST_PATTERN = PAT_W'(3'b101);

  logic [PAT_W-1:0] history_q, history_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             overlap_q, overlap_d;
  logic             detector_out_q, detector_out_d;

  logic [PAT_W-1:0] shifted;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] eff_len;
  logic             fill_ok;
  logic             match;

  // The oldest history bit drops out on the next shift. It is never compared.
  logic unused_history_msb;
  assign unused_history_msb = history_q[PAT_W-1];

  // Match decode: compare the shifted-in history against the pattern over eff_len bits.
  // cfg_load takes priority and discards the incoming bit.
  always_comb begin
    eff_len = (len_q > PAT_W_L) ? PAT_W_L : len_q;
    shifted = {history_q[PAT_W-2:0], sequence_in};
    mask    = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < eff_len);
    end
    fill_ok = (({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, eff_len});
    match   = in_valid && !cfg_load && (len_q >= MIN_LEN) && fill_ok &&
              ((shifted & mask) == (pattern_q & mask));
  end

  // Next-state logic for the configuration, history and fill registers, and the pulse.
  always_comb begin
    history_d      = history_q;
    fill_d         = fill_q;
    pattern_d      = pattern_q;
    len_d          = len_q;
    overlap_d      = overlap_q;
    detector_out_d = 1'b0;
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = cfg_len;
      overlap_d = cfg_overlap;
      history_d = '0;
      fill_d    = '0;
    end else if (in_valid) begin
      history_d      = shifted;
      detector_out_d = match;
      if (match && !overlap_q) begin
        fill_d = '0;
      end else if (fill_q < PAT_W_L) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  // State registers. Reset is asynchronous and restores the default 3-bit pattern 101, with overlap on.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      history_q      <= '0;
      fill_q         <= '0;
      pattern_q      <= RST_PATTERN;
      len_q          <= RST_LEN;
      overlap_q      <= 1'b1;
      detector_out_q <= 1'b0;
    end else begin
      history_q      <= history_d;
      fill_q         <= fill_d;
      pattern_q      <= pattern_d;
      len_q          <= len_d;
      overlap_q      <= overlap_d;
      detector_out_q <= detector_out_d;
    end
  end

  assign detector_out = detector_out_q;

`ifdef SEQDET_MATCH_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q, count_d;

  // Saturating match counter. A clear overrides a coincident match.
  always_comb begin
    count_d = count_q;
    if (count_clear) begin
      count_d = '0;
    end else if (match && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register. Reset clears it asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign match_count = count_q;
`else
  logic unused_count_clear;
  assign unused_count_clear = count_clear;
  assign match_count        = '0;
`endif

endmodule

// File: doc/seq_pattern_detector.md
SEQ_PATTERN_DETECTOR -- requirements
Module: seq_pattern_detector

Interface
REQ-001 The block SHALL have parameter PAT_W, default 8: maximum pattern length in bits, legal range 2..32.
REQ-002 The block SHALL have parameter LEN_W, default 4: width of the pattern length field; 2^LEN_W SHALL be greater than PAT_W.
REQ-003 The block SHALL have parameter CNT_W, default 16: width of the match counter.
REQ-004 The block SHALL have the following ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- sequence_in  input  1  serial data bit.
- in_valid  input  1  sequence_in is sampled only when this is high.
- cfg_load  input  1  single-cycle strobe that latches cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  input  PAT_W  target pattern, right-aligned; bit [cfg_len-1] is the first bit expected.
- cfg_len  input  LEN_W  pattern length in bits.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping detection.
- count_clear  input  1  synchronous clear of match_count.
- detector_out  output  1  registered single-cycle match pulse.
- match_count  output  CNT_W  saturating count of matches.

Function
REQ-005 On each in_valid cycle, the history register SHALL shift left by one with sequence_in entering at bit 0; fill SHALL increment, saturating at PAT_W.
REQ-006 A match SHALL occur on a valid cycle when fill+1 >= eff_len and the low eff_len bits of the updated history equal the low eff_len bits of the pattern.
REQ-007 eff_len SHALL equal min(len, PAT_W); when len < 2, matching SHALL be disabled.
REQ-008 detector_out SHALL go high for exactly one clock, on the edge that accepts the final pattern bit (one-cycle latency from sampling that bit); otherwise it SHALL be 0.
REQ-009 When in_valid is low, the history register, fill, and the pattern registers SHALL hold, and detector_out SHALL be 0.
REQ-010 In overlap mode, fill SHALL be unaffected by a match, so the pattern suffix may start the next match.
REQ-011 In non-overlap mode, a match SHALL clear fill to 0, so the next match requires eff_len fresh bits.
REQ-012 cfg_load SHALL latch pattern, len and overlap, and SHALL clear history, fill and detector_out on the same edge.
REQ-013 When cfg_load and in_valid are asserted in the same cycle, cfg_load SHALL win and the bit SHALL be discarded.
REQ-014 match_count SHALL increment by 1 per match and saturate at 2^CNT_W-1 without wrapping.
REQ-015 When count_clear coincides with a match, match_count SHALL become 0 (clear wins).
REQ-016 cfg_load SHALL NOT alter match_count.

Reset
REQ-017 On reset assertion, without waiting for a clock edge, the block SHALL set:
- history = 0, fill = 0
- detector_out = 0, match_count = 0
- pattern = 'b101 zero-extended, len = 3, overlap = 1
REQ-018 Reset asserted mid-pattern SHALL discard partial progress; after release, a full eff_len bits SHALL be needed before any match.

Configuration
REQ-019 With SEQDET_MATCH_COUNT_EN defined, the block SHALL implement match_count and count_clear as specified in REQ-014..REQ-016.
REQ-020 Without SEQDET_MATCH_COUNT_EN, match_count SHALL be tied to 0, count_clear SHALL be ignored, and no counter flops SHALL be inferred; all other behaviour SHALL be unchanged.

Verification
REQ-021 Bench SHALL check: reset defaults, valid bits 1,0,1,0,1 -> detector_out pulses after bits 3 and 5; match_count = 2.
REQ-022 Bench SHALL check: cfg_load with cfg_overlap=0 and the same pattern, bits 1,0,1,0,1 -> a single pulse after bit 3; match_count increments by 1.
REQ-023 Bench SHALL check: cfg_pattern=8'b11010110, cfg_len=8, the bits applied with in_valid low for 2 cycles between each bit -> exactly one pulse, one clock after the last bit is sampled.
REQ-024 Bench SHALL check: cfg_load in the same cycle as the completing bit -> no pulse, and history is cleared.
REQ-025 Bench SHALL check: with CNT_W=3, 9 matches -> match_count holds at 7; count_clear coinciding with the next match -> match_count = 0.
REQ-026 Bench SHALL check: reset asserted after bits 1,0 of pattern 101, then released -> input 1 gives no pulse, and a further 0,1 gives a pulse.
